// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch and data requests onto one memory port, with dump/halt sequencing.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [15:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_wr,
   input  logic [15:0] dm_addr,
   input  logic [15:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic [15:0] dm_rdata,
   input  logic        dump_req,
   output logic        halted,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   input  logic [15:0] mem_data_out,
   output logic        mem_createdump
);
   typedef enum logic [1:0] {RUN, DUMP, HALTED} state_t;
   state_t state, state_nxt;
   logic run, starve, if_rv, dm_rv;
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..7");
   end
   assign run = state == RUN && !rst;
`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [2:0] cnt;
   assign starve = cnt == 3'(STARVE_LIMIT);
   always_ff @(posedge clk)
      if (rst || if_gnt || !if_req) cnt <= '0;
      else if (!starve) cnt <= cnt + 3'd1;
`else
   assign starve = 1'b0;
`endif
   always_comb begin
      state_nxt = state;
      state_nxt = state == RUN ? (dump_req ? DUMP : RUN) : HALTED;
   end
   always_ff @(posedge clk) state <= rst ? RUN : state_nxt;
   assign dm_gnt         = run && dm_req && !(starve && if_req);
   assign if_gnt         = run && if_req && !dm_gnt;
   assign mem_enable     = if_gnt || dm_gnt;
   assign mem_wr         = dm_gnt && dm_wr;
   assign mem_addr       = dm_gnt ? dm_addr : if_gnt ? if_addr : 16'h0;
   assign mem_data_in    = dm_gnt ? dm_wdata : 16'h0;
   assign mem_createdump = state == DUMP && !rst;
   assign halted         = state == HALTED;
   // rst suppresses a read response already in flight
   assign if_rvalid = if_rv && !rst;
   assign dm_rvalid = dm_rv && !rst;
   always_ff @(posedge clk)
      if (rst) begin
         if_rv    <= 1'b0;
         dm_rv    <= 1'b0;
         if_rdata <= '0;
         dm_rdata <= '0;
      end else begin
         if_rv <= if_gnt;
         dm_rv <= dm_gnt && !dm_wr;
         if (if_gnt) if_rdata <= mem_data_out;
         if (dm_gnt && !dm_wr) dm_rdata <= mem_data_out;
      end
endmodule
